// File: rtl/id_arb.sv
`default_nettype none
// ============================================================================
// Module   : id_arb
// Purpose  : Two-requester round-robin arbiter feeding an identifier scanner
//            that counts letter-then-digit tokens per requester.
// Revision : 1.0 - initial release
// ============================================================================
module id_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [7:0] req0_char,
    input  logic [7:0] req1_char,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic [1:0] grant,
    output logic       scan_valid,
    output logic [7:0] scan_char,
    output logic       id_done,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1
);

    // State encodings double as the one-hot grant value.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SC_T0 = 2'd0,
        SC_T1 = 2'd1,
        SC_T2 = 2'd2
    } scan_t;

    localparam logic [4:0] c_LAST_LEN = 5'd15;
    localparam logic [7:0] c_CNT_MAX  = 8'hFF;

    state_t     r_state, w_state_nxt;
    scan_t      r_scan,  w_scan_nxt;
    logic [4:0] r_len,   w_len_nxt;
    logic       r_last,  w_last_nxt;
    logic [7:0] r_cnt0,  r_cnt1;

    logic       w_sel;
    logic       w_xfer;
    logic [7:0] w_char;
    logic       w_letter;
    logic       w_digit;
    logic       w_id_end;

    assign req0_ready = (r_state == ST_OWN0);
    assign req1_ready = (r_state == ST_OWN1);
    assign w_sel      = req1_ready;
    assign w_char     = w_sel ? req1_char : req0_char;
    assign w_xfer     = (req0_ready && req0_valid) || (req1_ready && req1_valid);

    assign w_letter = ((w_char >= 8'h41) && (w_char <= 8'h5A)) ||
                      ((w_char >= 8'h61) && (w_char <= 8'h7A));
    assign w_digit  = (w_char >= 8'h30) && (w_char <= 8'h39);

    assign grant      = r_state;
    assign scan_valid = w_xfer;
    assign scan_char  = w_xfer ? w_char : 8'h00;
    assign id_done    = w_id_end;
    assign cnt0       = r_cnt0;
    assign cnt1       = r_cnt1;

    always_comb begin
        w_state_nxt = r_state;
        w_scan_nxt  = r_scan;
        w_len_nxt   = r_len;
        w_last_nxt  = r_last;
        w_id_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_last high means requester 1 was served last, so 0 wins a tie.
                if (req0_valid && (!req1_valid || r_last)) begin
                    w_state_nxt = ST_OWN0;
                    w_len_nxt   = 5'd0;
                    w_scan_nxt  = SC_T0;
                end else if (req1_valid) begin
                    w_state_nxt = ST_OWN1;
                    w_len_nxt   = 5'd0;
                    w_scan_nxt  = SC_T0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (w_xfer) begin
                    if (!w_letter && !w_digit) begin
                        w_id_end    = (r_scan == SC_T2);
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = w_sel;
                        w_scan_nxt  = SC_T0;
                    end else begin
                        w_len_nxt = r_len + 5'd1;
                        if (r_len == c_LAST_LEN) begin
                            // Overlong token: give up the scanner without counting.
                            w_state_nxt = ST_IDLE;
                            w_last_nxt  = w_sel;
                            w_scan_nxt  = SC_T0;
                        end else if (w_letter) begin
                            w_scan_nxt = SC_T1;
                        end else if (r_scan != SC_T0) begin
                            w_scan_nxt = SC_T2;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_scan  <= SC_T0;
            r_len   <= 5'd0;
            r_last  <= 1'b1;
            r_cnt0  <= 8'h00;
            r_cnt1  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_scan  <= w_scan_nxt;
            r_len   <= w_len_nxt;
            r_last  <= w_last_nxt;
            if (w_id_end && !w_sel && (r_cnt0 != c_CNT_MAX)) begin
                r_cnt0 <= r_cnt0 + 8'd1;
            end
            if (w_id_end && w_sel && (r_cnt1 != c_CNT_MAX)) begin
                r_cnt1 <= r_cnt1 + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_arb
// Purpose  : Self-checking bench for id_arb: directed scenarios plus a
//            randomized run against a token-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_arb;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0;
    logic       req1_valid = 1'b0;
    logic [7:0] req0_char = 8'h00;
    logic [7:0] req1_char = 8'h00;
    logic       req0_ready, req1_ready;
    logic [1:0] grant;
    logic       scan_valid;
    logic [7:0] scan_char;
    logic       id_done;
    logic [7:0] cnt0, cnt1;

    int errors = 0;
    int checks = 0;

    id_arb dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_char  (req0_char),
        .req1_char  (req1_char),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .grant      (grant),
        .scan_valid (scan_valid),
        .scan_char  (scan_char),
        .id_done    (id_done),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are observed on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic bit is_letter(input logic [7:0] c);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction

    function automatic bit is_digit(input logic [7:0] c);
        return (c >= "0" && c <= "9");
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req0_char = "a";
        req1_valid = 1'b1; req1_char = "b";
        tick();
        mid();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
        checks++; if (scan_valid !== 1'b0 || scan_char !== 8'h00) begin errors++; $display("FAIL reset_scan: got %b/%h want 0/00", scan_valid, scan_char); end
        checks++; if (id_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", id_done); end
        checks++; if (cnt0 !== 8'h00 || cnt1 !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h/%h want 00/00", cnt0, cnt1); end
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        string s;
        s = "ab12 ";
        do_reset();
        req0_valid = 1'b1;
        req0_char  = s[0];
        mid();
        checks++; if (grant !== 2'b00 || req0_ready !== 1'b0) begin errors++; $display("FAIL basic_arb_cycle: got grant=%b rdy=%b want 00/0", grant, req0_ready); end
        tick();
        for (int i = 0; i < s.len(); i++) begin
            req0_char = s[i];
            mid();
            checks++; if (grant !== 2'b01 || scan_valid !== 1'b1 || scan_char !== s[i]) begin
                errors++; $display("FAIL basic_xfer%0d: got grant=%b sv=%b ch=%h want 01/1/%h", i, grant, scan_valid, scan_char, s[i]);
            end
            checks++; if (id_done !== (s[i] == " ")) begin errors++; $display("FAIL basic_done%0d: got %b want %b", i, id_done, (s[i] == " ")); end
            tick();
        end
        req0_valid = 1'b0;
        mid();
        checks++; if (grant !== 2'b00 || cnt0 !== 8'd1) begin errors++; $display("FAIL basic_end: got grant=%b cnt0=%0d want 00/1", grant, cnt0); end
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        req0_valid = 1'b1; req0_char = " ";
        req1_valid = 1'b1; req1_char = "q";
        tick();
        mid();
        checks++; if (grant !== 2'b01 || req1_ready !== 1'b0) begin errors++; $display("FAIL tie_first: got grant=%b rdy1=%b want 01/0", grant, req1_ready); end
        checks++; if (id_done !== 1'b0) begin errors++; $display("FAIL tie_done: got %b want 0", id_done); end
        tick();
        mid();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_idle: got %b want 00", grant); end
        tick();
        mid();
        checks++; if (grant !== 2'b10 || cnt0 !== 8'd0) begin errors++; $display("FAIL tie_second: got grant=%b cnt0=%0d want 10/0", grant, cnt0); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_no_count();
        string s;
        s = "9x ";
        do_reset();
        req1_valid = 1'b1;
        req1_char  = s[0];
        tick();
        for (int i = 0; i < s.len(); i++) begin
            req1_char = s[i];
            mid();
            checks++; if (grant !== 2'b10 || scan_char !== s[i] || id_done !== 1'b0) begin
                errors++; $display("FAIL nocnt_xfer%0d: got grant=%b ch=%h done=%b want 10/%h/0", i, grant, scan_char, id_done, s[i]);
            end
            tick();
        end
        req1_valid = 1'b0;
        mid();
        checks++; if (grant !== 2'b00 || cnt1 !== 8'd0) begin errors++; $display("FAIL nocnt_end: got grant=%b cnt1=%0d want 00/0", grant, cnt1); end
        tick();
    endtask

    task automatic test_force_release();
        int dones;
        dones = 0;
        do_reset();
        req0_valid = 1'b1;
        req0_char  = "a";
        tick();
        for (int i = 0; i < 16; i++) begin
            req0_char = 8'("a" + (i % 26));
            mid();
            if (id_done === 1'b1) dones++;
            checks++; if (scan_valid !== 1'b1) begin errors++; $display("FAIL force_xfer%0d: got sv=%b want 1", i, scan_valid); end
            tick();
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL force_nodone: got %0d pulses want 0", dones); end
        req0_char = "q";
        mid();
        checks++; if (grant !== 2'b00 || req0_ready !== 1'b0 || scan_valid !== 1'b0) begin
            errors++; $display("FAIL force_release: got grant=%b rdy=%b sv=%b want 00/0/0", grant, req0_ready, scan_valid);
        end
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL force_cnt: got %0d want 0", cnt0); end
        tick();
        mid();
        checks++; if (grant !== 2'b01 || scan_char !== "q") begin errors++; $display("FAIL force_regrant: got grant=%b ch=%h want 01/71", grant, scan_char); end
        req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        string s;
        s = "a1 ";
        do_reset();
        req0_valid = 1'b1;
        req0_char  = "a";
        tick();
        tick();
        req0_char = "1";
        tick();
        req0_char = " ";
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1'b0;
        mid();
        checks++; if (grant !== 2'b00 || cnt0 !== 8'd0) begin errors++; $display("FAIL rstmid_state: got grant=%b cnt0=%0d want 00/0", grant, cnt0); end
        tick();
        req0_valid = 1'b1;
        req0_char  = s[0];
        tick();
        for (int i = 0; i < s.len(); i++) begin
            req0_char = s[i];
            tick();
        end
        req0_valid = 1'b0;
        mid();
        checks++; if (cnt0 !== 8'd1) begin errors++; $display("FAIL rstmid_fresh: got cnt0=%0d want 1", cnt0); end
        tick();
    endtask

    task automatic test_saturate();
        string s;
        int    w;
        int    dones;
        s = "z0 ";
        dones = 0;
        do_reset();
        req1_valid = 1'b1;
        for (int t = 0; t < 256; t++) begin
            req1_char = s[0];
            w = 0;
            while (grant !== 2'b10 && w < 4) begin
                tick();
                w++;
            end
            if (w >= 4) begin
                checks++; errors++;
                $display("FAIL sat_grant_timeout: got grant=%b want 10 within 4 cycles", grant);
                break;
            end
            for (int k = 0; k < 3; k++) begin
                req1_char = s[k];
                mid();
                if (id_done === 1'b1) dones++;
                tick();
            end
            if (t == 254) begin
                checks++; if (cnt1 !== 8'hFF || dones != 255) begin errors++; $display("FAIL sat_preload: got cnt1=%h pulses=%0d want FF/255", cnt1, dones); end
            end
        end
        req1_valid = 1'b0;
        mid();
        checks++; if (cnt1 !== 8'hFF) begin errors++; $display("FAIL sat_hold: got cnt1=%h want FF", cnt1); end
        checks++; if (dones != 256) begin errors++; $display("FAIL sat_done: got %0d pulses want 256", dones); end
        checks++; if (cnt0 !== 8'h00) begin errors++; $display("FAIL sat_other: got cnt0=%h want 00", cnt0); end
        tick();
    endtask

    function automatic logic [7:0] rand_char(input int delim_w);
        logic [7:0] delims [9];
        int r;
        delims = '{" ", ",", "_", "@", "[", 8'h60, "{", "/", ":"};
        r = $urandom_range(0, 19);
        if (r < delim_w)                 return delims[$urandom_range(0, 8)];
        else if (r < delim_w + (20 - delim_w) / 3) return 8'("0" + $urandom_range(0, 9));
        else if ($urandom_range(0, 1) == 1)      return 8'("A" + $urandom_range(0, 25));
        else                                     return 8'("a" + $urandom_range(0, 25));
    endfunction

    // Reference: a token is counted when it contains a letter and its last character is a digit.
    task automatic test_random(input int ncyc);
        int               owner;
        int               last;
        int               len;
        logic [7:0]       tok[$];
        logic [7:0]       mcnt[2];
        logic [1:0]       e_grant;
        logic             e_xfer, e_done, has_letter;
        logic [7:0]       ch;
        logic             rst_now;
        do_reset();
        owner = 0; last = 1; len = 0; tok.delete(); mcnt[0] = 8'h00; mcnt[1] = 8'h00;
        for (int i = 0; i < ncyc; i++) begin
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            req0_char  = rand_char(((i / 200) % 2 == 1) ? 1 : 6);
            req1_char  = rand_char(((i / 200) % 2 == 1) ? 1 : 6);
            rst_now    = ($urandom_range(0, 59) == 0);
            reset      = rst_now;
            mid();
            e_grant = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
            e_xfer  = (owner == 1 && req0_valid) || (owner == 2 && req1_valid);
            ch      = (owner == 2) ? req1_char : req0_char;
            has_letter = 1'b0;
            foreach (tok[k]) if (is_letter(tok[k])) has_letter = 1'b1;
            e_done = e_xfer && !is_letter(ch) && !is_digit(ch) && has_letter &&
                     (tok.size() > 0) && is_digit(tok[tok.size() - 1]);
            checks++; if (grant !== e_grant || req0_ready !== (owner == 1) || req1_ready !== (owner == 2)) begin
                errors++; $display("FAIL rnd_grant@%0d: got grant=%b rdy=%b%b want %b", i, grant, req1_ready, req0_ready, e_grant);
            end
            checks++; if (scan_valid !== e_xfer || scan_char !== (e_xfer ? ch : 8'h00)) begin
                errors++; $display("FAIL rnd_scan@%0d: got %b/%h want %b/%h", i, scan_valid, scan_char, e_xfer, e_xfer ? ch : 8'h00);
            end
            checks++; if (id_done !== e_done) begin errors++; $display("FAIL rnd_done@%0d: got %b want %b", i, id_done, e_done); end
            checks++; if (cnt0 !== mcnt[0] || cnt1 !== mcnt[1]) begin
                errors++; $display("FAIL rnd_cnt@%0d: got %h/%h want %h/%h", i, cnt0, cnt1, mcnt[0], mcnt[1]);
            end
            if (rst_now) begin
                owner = 0; last = 1; len = 0; tok.delete(); mcnt[0] = 8'h00; mcnt[1] = 8'h00;
            end else if (owner == 0) begin
                if (req0_valid && (!req1_valid || last == 1)) owner = 1;
                else if (req1_valid) owner = 2;
                len = 0;
                tok.delete();
            end else if (e_xfer) begin
                if (!is_letter(ch) && !is_digit(ch)) begin
                    if (e_done && mcnt[owner - 1] != 8'hFF) mcnt[owner - 1] = mcnt[owner - 1] + 8'd1;
                    last = owner - 1;
                    owner = 0;
                    tok.delete();
                end else begin
                    len++;
                    tok.push_back(ch);
                    if (len == 16) begin
                        last = owner - 1;
                        owner = 0;
                        tok.delete();
                    end
                end
            end
            tick();
        end
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_no_count();
        test_force_release();
        test_reset_mid();
        test_saturate();
        test_random(3000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
